gbn_tx_window: RTL and testbench
================================

Name: gbn_tx_window

Overview:
- Per-session go-back-N sender window for the relnet reliable transport.
- Allocates sequence numbers to outgoing data packets and absorbs cumulative ACK/NACK from the peer.
- Runs a per-session retransmission timer and emits retransmit-range requests to the TX replay path.
- Parametrised successor of the single-session fixed-window GBN sender: session count, window depth, sequence width and timeout are all generics.

Parameters:
NUM_SESSIONS, 32, number of independent sessions (slots); SESS_W = clog2(NUM_SESSIONS)
SEQ_WIDTH, 32, sequence number width; all seq arithmetic is modulo 2^SEQ_WIDTH
WINDOW_SIZE, 16, max outstanding unacked packets per session; must be < 2^(SEQ_WIDTH-1)
TIMEOUT_CYCLES, 4096, idle cycles with outstanding data before a timeout retransmit; TMR_W = clog2(TIMEOUT_CYCLES)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
open_valid  in  1  session (re)open strobe (SYN accepted)
open_sess  in  SESS_W  session to reset
tx_req_valid  in  1  request a sequence number for a new data packet
tx_req_ready  out  1  request accepted this cycle
tx_req_sess  in  SESS_W  requesting session
tx_seq  out  SEQ_WIDTH  sequence number granted (valid when tx_req_valid & tx_req_ready)
ack_valid  in  1  ACK/NACK from peer; always accepted
ack_is_nack  in  1  0 = ACK, 1 = NACK
ack_sess  in  SESS_W  session
ack_seq  in  SEQ_WIDTH  ACK: last in-order seq received; NACK: seq receiver expects
rt_valid  out  1  retransmit request
rt_ready  in  1  replay path accepts request
rt_sess  out  SESS_W  session to replay
rt_first  out  SEQ_WIDTH  first seq to resend
rt_last  out  SEQ_WIDTH  last seq to resend (inclusive)

Behaviour:
- Per-session state: base (oldest unacked), next (next to allocate), timer, rt_pend flag.
- Reset: base = next = 1, timer = 0, rt_pend = 0 for all sessions. rt_valid = 0; rt_sess, rt_first and rt_last = 0.
- Reset mid-operation discards all outstanding state, including a stalled rt beat.
- Open: session base = next = 1, timer = 0, rt_pend = 0. In the same cycle, on that session:
  - tx_req_ready = 0;
  - ack is dropped;
  - a pending/timeout set is suppressed.
- Alloc:
  - tx_req_ready = !(next - base == WINDOW_SIZE) && !(open_valid && open_sess == tx_req_sess). Ready is combinational on tx_req_sess.
  - tx_seq = next (combinational). On handshake, next <= next + 1, wrapping at 2^SEQ_WIDTH.
- In-range test: d = seq - base, out = next - base, both modulo 2^SEQ_WIDTH.
  - ACK valid if d < out: base <= ack_seq + 1.
  - NACK valid if d <= out: base <= ack_seq. If ack_seq != next, set rt_pend.
  - Out-of-range ACK/NACK is ignored; no state change.
- Same-cycle alloc and ack on one session:
  - both apply;
  - the range test uses pre-cycle next;
  - the new next is the pre-cycle next + 1.
- Timer:
  - Clears when base == next.
  - Clears when base advances.
  - Clears when a timeout fires.
  - Otherwise increments each cycle.
  - At TIMEOUT_CYCLES-1 with base != next: set rt_pend, timer <= 0.
- Retransmit arbiter:
  - Round-robin over sessions with rt_pend, starting after the last granted session.
  - When rt_valid is 0 or rt_ready is 1, load the output register:
    - rt_sess = the winning session;
    - rt_first = its current base;
    - rt_last = next - 1;
    - clear its rt_pend.
  - If at load time the winner has base == next (acked meanwhile), clear rt_pend and do not assert rt_valid.
  - rt_valid/rt_* are held stable until rt_ready (AXI-stream rule).
  - Multiple NACK/timeouts on one session before grant coalesce into a single request.
  - A new set in the cycle its flag is cleared takes precedence and leaves rt_pend = 1.
- Latency:
  - alloc: 0 cycles;
  - ack state update: 1 cycle;
  - NACK -> rt_valid: 2 cycles minimum (flag, then output register).

Optional Feature:
GBN_TX_STATS_EN
- Present: adds outputs stat_rt_cnt[31:0], stat_timeout_cnt[31:0] and stat_stale_cnt[31:0].
  - stat_rt_cnt: rt handshakes.
  - stat_timeout_cnt: timer expiries.
  - stat_stale_cnt: ignored ACK/NACK.
  - All counters saturate at all-ones and reset to 0.
- Absent: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset, then 7 allocs on session 20 -> tx_seq 1..7, tx_req_ready high throughout; session 20 next = 8, base = 1.
- Continue allocs until next - base = 16 -> tx_req_ready drops at the request for seq 17. ACK seq 4 -> ready returns the next cycle, seq 17 granted.
- Seq 1..7 outstanding, NACK seq 3 -> rt_valid two cycles later with rt_sess = 20, rt_first = 3, rt_last = 7. Hold rt_ready low 5 cycles -> outputs stable.
- Seq 1..3 outstanding, no acks for 4096 cycles (TIMEOUT_CYCLES=4096) -> rt_first = 1, rt_last = 3. ACK seq 3 -> timer stays 0, no further rt.
- NACK on sessions 5 and 9 same window, rt_ready held high -> grants alternate in round-robin order (5 then 9). Stale ACK seq 100 on session 5 -> no state change.
- SEQ_WIDTH=4, cross the wrap (alloc 14, 15, 0, 1), ACK seq 0 -> base = 1. Open on session 20 concurrent with alloc -> tx_req_ready = 0, state back to base = next = 1.

Source files
------------

// File: rtl/gbn_tx_window_if.sv
// Handshake bundle between the relnet TX data path and the go-back-N sender window.
// The master side drives requests, ACK/NACK and rt_ready; the slave side is the window.
interface gbn_tx_window_if #(
  parameter int SESS_W    = 5,
  parameter int SEQ_WIDTH = 32
);
  logic                 open_valid;
  logic [SESS_W-1:0]    open_sess;
  logic                 tx_req_valid;
  logic                 tx_req_ready;
  logic [SESS_W-1:0]    tx_req_sess;
  logic [SEQ_WIDTH-1:0] tx_seq;
  logic                 ack_valid;
  logic                 ack_is_nack;
  logic [SESS_W-1:0]    ack_sess;
  logic [SEQ_WIDTH-1:0] ack_seq;
  logic                 rt_valid;
  logic                 rt_ready;
  logic [SESS_W-1:0]    rt_sess;
  logic [SEQ_WIDTH-1:0] rt_first;
  logic [SEQ_WIDTH-1:0] rt_last;

  modport master (
    output open_valid, open_sess, tx_req_valid, tx_req_sess,
           ack_valid, ack_is_nack, ack_sess, ack_seq, rt_ready,
    input  tx_req_ready, tx_seq, rt_valid, rt_sess, rt_first, rt_last
  );

  modport slave (
    input  open_valid, open_sess, tx_req_valid, tx_req_sess,
           ack_valid, ack_is_nack, ack_sess, ack_seq, rt_ready,
    output tx_req_ready, tx_seq, rt_valid, rt_sess, rt_first, rt_last
  );
endinterface

// File: rtl/gbn_tx_window.sv
// Per-session go-back-N sender window: seq allocation, cumulative ACK/NACK, retransmit timer
// and round-robin retransmit request arbiter. Define GBN_TX_STATS_EN to add saturating stat counters.
module gbn_tx_window #(
  parameter int  NUM_SESSIONS   = 32,
  parameter int  SEQ_WIDTH      = 32,
  parameter int  WINDOW_SIZE    = 16,
  parameter int  TIMEOUT_CYCLES = 4096,
  localparam int SESS_W         = $clog2(NUM_SESSIONS),
  localparam int TMR_W          = $clog2(TIMEOUT_CYCLES)
) (
  input logic           clk,
  input logic           rst,
  gbn_tx_window_if.slave bus
`ifdef GBN_TX_STATS_EN
  ,
  output logic [31:0]   stat_rt_cnt,
  output logic [31:0]   stat_timeout_cnt,
  output logic [31:0]   stat_stale_cnt
`endif
);

  typedef logic [SEQ_WIDTH-1:0] seq_t;
  localparam seq_t             ONE      = seq_t'(1);
  localparam seq_t             WIN      = seq_t'(WINDOW_SIZE);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  seq_t               base_q  [NUM_SESSIONS];
  seq_t               next_q  [NUM_SESSIONS];
  logic [TMR_W-1:0]   timer_q [NUM_SESSIONS];
  seq_t               base_d  [NUM_SESSIONS];
  seq_t               next_d  [NUM_SESSIONS];
  logic [TMR_W-1:0]   timer_d [NUM_SESSIONS];
  logic [NUM_SESSIONS-1:0] pend_q, pend_d, to_fire;

  logic               rt_valid_q;
  logic [SESS_W-1:0]  rt_sess_q, last_q;
  seq_t               rt_first_q, rt_last_q;

  seq_t               req_out, ack_d, ack_out, ack_new_base;
  logic               alloc, ack_hit, ack_in, ack_apply, nack_set;
  logic               load, win_found;
  logic [SESS_W-1:0]  win_idx, cand;

  assign req_out          = next_q[bus.tx_req_sess] - base_q[bus.tx_req_sess];
  assign bus.tx_req_ready = (req_out != WIN) && !(bus.open_valid && bus.open_sess == bus.tx_req_sess);
  assign bus.tx_seq       = next_q[bus.tx_req_sess];
  assign alloc            = bus.tx_req_valid && bus.tx_req_ready;

  // Range test against pre-cycle base/next; an open on the same session drops the ack.
  assign ack_d        = bus.ack_seq - base_q[bus.ack_sess];
  assign ack_out      = next_q[bus.ack_sess] - base_q[bus.ack_sess];
  assign ack_hit      = bus.ack_valid && !(bus.open_valid && bus.open_sess == bus.ack_sess);
  assign ack_in       = bus.ack_is_nack ? (ack_d <= ack_out) : (ack_d < ack_out);
  assign ack_apply    = ack_hit && ack_in;
  assign ack_new_base = bus.ack_is_nack ? bus.ack_seq : bus.ack_seq + ONE;
  assign nack_set     = ack_apply && bus.ack_is_nack && (bus.ack_seq != next_q[bus.ack_sess]);

  assign load = !rt_valid_q || bus.rt_ready;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_SESSIONS; k++) begin
      cand = SESS_W'((int'(last_q) + k) % NUM_SESSIONS);
      if (!win_found && pend_q[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    pend_d  = pend_q;
    to_fire = '0;
    for (int i = 0; i < NUM_SESSIONS; i++) begin
      base_d[i]  = base_q[i];
      next_d[i]  = next_q[i];
      timer_d[i] = timer_q[i];
      if (bus.open_valid && bus.open_sess == SESS_W'(i)) begin
        base_d[i]  = ONE;
        next_d[i]  = ONE;
        timer_d[i] = '0;
        pend_d[i]  = 1'b0;
      end else begin
        if (alloc && bus.tx_req_sess == SESS_W'(i))
          next_d[i] = next_q[i] + ONE;
        if (ack_apply && bus.ack_sess == SESS_W'(i))
          base_d[i] = ack_new_base;
        if (base_q[i] == next_q[i] || base_d[i] != base_q[i]) begin
          timer_d[i] = '0;
        end else if (timer_q[i] == TMR_LAST) begin
          timer_d[i] = '0;
          to_fire[i] = 1'b1;
        end else begin
          timer_d[i] = timer_q[i] + 1'b1;
        end
        // A new set wins over the arbiter clearing the flag in the same cycle.
        if (to_fire[i] || (nack_set && bus.ack_sess == SESS_W'(i)))
          pend_d[i] = 1'b1;
        else if (load && win_found && win_idx == SESS_W'(i))
          pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SESSIONS; i++) begin
        base_q[i]  <= ONE;
        next_q[i]  <= ONE;
        timer_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SESSIONS; i++) begin
        base_q[i]  <= base_d[i];
        next_q[i]  <= next_d[i];
        timer_q[i] <= timer_d[i];
      end
      pend_q <= pend_d;
    end
  end

  // A winner that was fully acked while pending is consumed without a beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      rt_valid_q <= 1'b0;
      rt_sess_q  <= '0;
      rt_first_q <= '0;
      rt_last_q  <= '0;
      last_q     <= SESS_W'(NUM_SESSIONS - 1);
    end else if (load) begin
      rt_valid_q <= 1'b0;
      if (win_found) begin
        last_q <= win_idx;
        if (base_q[win_idx] != next_q[win_idx]) begin
          rt_valid_q <= 1'b1;
          rt_sess_q  <= win_idx;
          rt_first_q <= base_q[win_idx];
          rt_last_q  <= next_q[win_idx] - ONE;
        end
      end
    end
  end

  assign bus.rt_valid = rt_valid_q;
  assign bus.rt_sess  = rt_sess_q;
  assign bus.rt_first = rt_first_q;
  assign bus.rt_last  = rt_last_q;

`ifdef GBN_TX_STATS_EN
  logic        ack_stale;
  logic [32:0] tmo_sum;
  assign ack_stale = ack_hit && !ack_in;
  assign tmo_sum   = {1'b0, stat_timeout_cnt} + 33'($countones(to_fire));

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rt_cnt      <= '0;
      stat_timeout_cnt <= '0;
      stat_stale_cnt   <= '0;
    end else begin
      if (rt_valid_q && bus.rt_ready && stat_rt_cnt != '1)
        stat_rt_cnt <= stat_rt_cnt + 32'd1;
      stat_timeout_cnt <= tmo_sum[32] ? '1 : tmo_sum[31:0];
      if (ack_stale && stat_stale_cnt != '1)
        stat_stale_cnt <= stat_stale_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gbn_tx_window.sv
// Directed bench for gbn_tx_window: a 32-bit-seq instance for window/ack/retransmit/timeout
// scenarios and a 4-bit-seq instance for sequence wrap-around.
module tb_gbn_tx_window;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gbn_tx_window_if #(.SESS_W(5), .SEQ_WIDTH(32)) b0 ();
  gbn_tx_window_if #(.SESS_W(5), .SEQ_WIDTH(4))  b1 ();

`ifdef GBN_TX_STATS_EN
  logic [31:0] s0_rt, s0_tmo, s0_stale, s1_rt, s1_tmo, s1_stale;
`endif

  gbn_tx_window #(.NUM_SESSIONS(32), .SEQ_WIDTH(32), .WINDOW_SIZE(16), .TIMEOUT_CYCLES(4096)) u0 (
    .clk(clk), .rst(rst), .bus(b0)
`ifdef GBN_TX_STATS_EN
    , .stat_rt_cnt(s0_rt), .stat_timeout_cnt(s0_tmo), .stat_stale_cnt(s0_stale)
`endif
  );

  gbn_tx_window #(.NUM_SESSIONS(32), .SEQ_WIDTH(4), .WINDOW_SIZE(4), .TIMEOUT_CYCLES(64)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
`ifdef GBN_TX_STATS_EN
    , .stat_rt_cnt(s1_rt), .stat_timeout_cnt(s1_tmo), .stat_stale_cnt(s1_stale)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b0.open_valid = 0; b0.open_sess = '0; b0.tx_req_valid = 0; b0.tx_req_sess = '0;
    b0.ack_valid = 0; b0.ack_is_nack = 0; b0.ack_sess = '0; b0.ack_seq = '0; b0.rt_ready = 1;
    b1.open_valid = 0; b1.open_sess = '0; b1.tx_req_valid = 0; b1.tx_req_sess = '0;
    b1.ack_valid = 0; b1.ack_is_nack = 0; b1.ack_sess = '0; b1.ack_seq = '0; b1.rt_ready = 1;
  endtask

  task automatic alloc0(input int sess, input int first, input int count);
    b0.tx_req_sess = 5'(sess);
    b0.tx_req_valid = 1;
    for (int n = first; n < first + count; n++) begin
      #1;
      checks++; if (b0.tx_req_ready !== 1'b1 || b0.tx_seq !== 32'(n)) begin errors++; $display("FAIL alloc s%0d: ready=%0b seq=%0d exp ready=1 seq=%0d", sess, b0.tx_req_ready, b0.tx_seq, n); end
      cyc();
    end
    b0.tx_req_valid = 0;
  endtask

  task automatic ack0(input int sess, input bit nack, input int seq);
    b0.ack_valid = 1; b0.ack_is_nack = nack; b0.ack_sess = 5'(sess); b0.ack_seq = 32'(seq);
    cyc();
    b0.ack_valid = 0;
  endtask

  task automatic open0(input int sess);
    b0.open_valid = 1; b0.open_sess = 5'(sess);
    cyc();
    b0.open_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    repeat (3) cyc();
    rst = 0;
    b0.tx_req_sess = 5'd20;
    b1.tx_req_sess = 5'd7;
    #1;
    checks++; if (b0.rt_valid !== 1'b0) begin errors++; $display("FAIL reset_rt_valid: got %0b exp 0", b0.rt_valid); end
    checks++; if (b0.rt_sess !== 5'd0 || b0.rt_first !== 32'd0 || b0.rt_last !== 32'd0) begin errors++; $display("FAIL reset_rt_fields: sess=%0d first=%0d last=%0d exp 0/0/0", b0.rt_sess, b0.rt_first, b0.rt_last); end
    checks++; if (b0.tx_req_ready !== 1'b1 || b0.tx_seq !== 32'd1) begin errors++; $display("FAIL reset_alloc: ready=%0b seq=%0d exp 1/1", b0.tx_req_ready, b0.tx_seq); end
    checks++; if (b1.tx_seq !== 4'd1) begin errors++; $display("FAIL reset_seq_w4: got %0d exp 1", b1.tx_seq); end
  endtask

  task automatic test_alloc();
    alloc0(20, 1, 7);
    #1;
    checks++; if (b0.tx_seq !== 32'd8) begin errors++; $display("FAIL alloc_next: got %0d exp 8", b0.tx_seq); end
  endtask

  task automatic test_window();
    alloc0(20, 8, 9);
    b0.tx_req_valid = 1;
    #1;
    checks++; if (b0.tx_req_ready !== 1'b0 || b0.tx_seq !== 32'd17) begin errors++; $display("FAIL window_full: ready=%0b seq=%0d exp 0/17", b0.tx_req_ready, b0.tx_seq); end
    ack0(20, 0, 4);
    #1;
    checks++; if (b0.tx_req_ready !== 1'b1 || b0.tx_seq !== 32'd17) begin errors++; $display("FAIL window_reopen: ready=%0b seq=%0d exp 1/17", b0.tx_req_ready, b0.tx_seq); end
    cyc();
    b0.tx_req_valid = 0;
    #1;
    checks++; if (b0.tx_seq !== 32'd18) begin errors++; $display("FAIL window_after17: got %0d exp 18", b0.tx_seq); end
  endtask

  task automatic test_nack_rt();
    open0(20);
    alloc0(20, 1, 7);
    b0.rt_ready = 0;
    b0.ack_valid = 1; b0.ack_is_nack = 1; b0.ack_sess = 5'd20; b0.ack_seq = 32'd3;
    #1;
    checks++; if (b0.rt_valid !== 1'b0) begin errors++; $display("FAIL nack_cycle0: rt_valid=%0b exp 0", b0.rt_valid); end
    cyc();
    b0.ack_valid = 0;
    #1;
    checks++; if (b0.rt_valid !== 1'b0) begin errors++; $display("FAIL nack_cycle1: rt_valid=%0b exp 0", b0.rt_valid); end
    cyc();
    checks++; if (b0.rt_valid !== 1'b1 || b0.rt_sess !== 5'd20 || b0.rt_first !== 32'd3 || b0.rt_last !== 32'd7) begin errors++; $display("FAIL nack_rt: v=%0b s=%0d f=%0d l=%0d exp 1/20/3/7", b0.rt_valid, b0.rt_sess, b0.rt_first, b0.rt_last); end
    for (int n = 0; n < 5; n++) begin
      cyc();
      checks++; if (b0.rt_valid !== 1'b1 || b0.rt_sess !== 5'd20 || b0.rt_first !== 32'd3 || b0.rt_last !== 32'd7) begin errors++; $display("FAIL nack_hold%0d: v=%0b s=%0d f=%0d l=%0d exp 1/20/3/7", n, b0.rt_valid, b0.rt_sess, b0.rt_first, b0.rt_last); end
    end
    rst = 1;
    cyc();
    rst = 0;
    b0.rt_ready = 1;
    #1;
    checks++; if (b0.rt_valid !== 1'b0 || b0.tx_seq !== 32'd1) begin errors++; $display("FAIL midop_reset: rt_valid=%0b seq=%0d exp 0/1", b0.rt_valid, b0.tx_seq); end
  endtask

  task automatic test_round_robin();
    alloc0(5, 1, 2);
    alloc0(9, 1, 3);
    b0.rt_ready = 0;
    ack0(5, 1, 1);
    ack0(9, 1, 2);
    #1;
    checks++; if (b0.rt_valid !== 1'b1 || b0.rt_sess !== 5'd5 || b0.rt_first !== 32'd1 || b0.rt_last !== 32'd2) begin errors++; $display("FAIL rr_first: v=%0b s=%0d f=%0d l=%0d exp 1/5/1/2", b0.rt_valid, b0.rt_sess, b0.rt_first, b0.rt_last); end
    cyc();
    checks++; if (b0.rt_sess !== 5'd5) begin errors++; $display("FAIL rr_stall: sess=%0d exp 5", b0.rt_sess); end
    b0.rt_ready = 1;
    cyc();
    checks++; if (b0.rt_valid !== 1'b1 || b0.rt_sess !== 5'd9 || b0.rt_first !== 32'd2 || b0.rt_last !== 32'd3) begin errors++; $display("FAIL rr_second: v=%0b s=%0d f=%0d l=%0d exp 1/9/2/3", b0.rt_valid, b0.rt_sess, b0.rt_first, b0.rt_last); end
    cyc();
    checks++; if (b0.rt_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: rt_valid=%0b exp 0", b0.rt_valid); end
    ack0(5, 0, 100);
    cyc();
    checks++; if (b0.rt_valid !== 1'b0) begin errors++; $display("FAIL stale_no_rt: rt_valid=%0b exp 0", b0.rt_valid); end
    ack0(5, 1, 1);
    cyc();
    checks++; if (b0.rt_valid !== 1'b1 || b0.rt_sess !== 5'd5 || b0.rt_first !== 32'd1 || b0.rt_last !== 32'd2) begin errors++; $display("FAIL stale_kept: v=%0b s=%0d f=%0d l=%0d exp 1/5/1/2", b0.rt_valid, b0.rt_sess, b0.rt_first, b0.rt_last); end
    cyc();
    open0(5);
    open0(9);
    cyc();
    checks++; if (b0.rt_valid !== 1'b0) begin errors++; $display("FAIL rr_cleanup: rt_valid=%0b exp 0", b0.rt_valid); end
  endtask

  task automatic test_timeout();
    int  n = 0;
    int  seen_cnt = 0;
    bit  seen = 0;
    alloc0(20, 1, 3);
    while (!seen && n < 6000) begin
      cyc();
      n++;
      if (b0.rt_valid === 1'b1) seen = 1;
    end
    checks++; if (!seen || n != 4095) begin errors++; $display("FAIL timeout_latency: seen=%0b cycles=%0d exp seen=1 cycles=4095", seen, n); end
    checks++; if (b0.rt_sess !== 5'd20 || b0.rt_first !== 32'd1 || b0.rt_last !== 32'd3) begin errors++; $display("FAIL timeout_rt: s=%0d f=%0d l=%0d exp 20/1/3", b0.rt_sess, b0.rt_first, b0.rt_last); end
    ack0(20, 0, 3);
    for (int k = 0; k < 4300; k++) begin
      cyc();
      if (b0.rt_valid === 1'b1) seen_cnt++;
    end
    checks++; if (seen_cnt != 0) begin errors++; $display("FAIL timeout_quiet: rt cycles=%0d exp 0", seen_cnt); end
  endtask

  task automatic test_open();
    alloc0(20, 4, 2);
    b0.tx_req_valid = 1; b0.tx_req_sess = 5'd20;
    b0.open_valid = 1; b0.open_sess = 5'd3;
    #1;
    checks++; if (b0.tx_req_ready !== 1'b1) begin errors++; $display("FAIL open_other: ready=%0b exp 1", b0.tx_req_ready); end
    b0.open_sess = 5'd20;
    b0.ack_valid = 1; b0.ack_is_nack = 0; b0.ack_sess = 5'd20; b0.ack_seq = 32'd4;
    #1;
    checks++; if (b0.tx_req_ready !== 1'b0) begin errors++; $display("FAIL open_same: ready=%0b exp 0", b0.tx_req_ready); end
    cyc();
    b0.open_valid = 0; b0.ack_valid = 0; b0.tx_req_valid = 0;
    #1;
    checks++; if (b0.tx_seq !== 32'd1 || b0.tx_req_ready !== 1'b1) begin errors++; $display("FAIL open_state: seq=%0d ready=%0b exp 1/1", b0.tx_seq, b0.tx_req_ready); end
  endtask

  task automatic test_wrap();
    int exp_seq [4] = '{14, 15, 0, 1};
    int errs_loop = 0;
    b1.tx_req_sess = 5'd7;
    for (int n = 1; n <= 13; n++) begin
      b1.tx_req_valid = 1;
      #1;
      if (b1.tx_seq !== 4'(n)) errs_loop++;
      cyc();
      b1.tx_req_valid = 0;
      b1.ack_valid = 1; b1.ack_is_nack = 0; b1.ack_sess = 5'd7; b1.ack_seq = 4'(n);
      cyc();
      b1.ack_valid = 0;
    end
    checks++; if (errs_loop != 0) begin errors++; $display("FAIL wrap_warmup: seq mismatches=%0d exp 0", errs_loop); end
    b1.tx_req_valid = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (b1.tx_req_ready !== 1'b1 || b1.tx_seq !== 4'(exp_seq[k])) begin errors++; $display("FAIL wrap_alloc%0d: ready=%0b seq=%0d exp 1/%0d", k, b1.tx_req_ready, b1.tx_seq, exp_seq[k]); end
      cyc();
    end
    b1.tx_req_valid = 0;
    #1;
    checks++; if (b1.tx_req_ready !== 1'b0) begin errors++; $display("FAIL wrap_full: ready=%0b exp 0", b1.tx_req_ready); end
    b1.ack_valid = 1; b1.ack_is_nack = 0; b1.ack_sess = 5'd7; b1.ack_seq = 4'd0;
    cyc();
    b1.ack_valid = 0;
    b1.tx_req_valid = 1;
    for (int n = 2; n <= 4; n++) begin
      #1;
      checks++; if (b1.tx_req_ready !== 1'b1 || b1.tx_seq !== 4'(n)) begin errors++; $display("FAIL wrap_post%0d: ready=%0b seq=%0d exp 1/%0d", n, b1.tx_req_ready, b1.tx_seq, n); end
      cyc();
    end
    b1.tx_req_valid = 0;
    #1;
    checks++; if (b1.tx_req_ready !== 1'b0) begin errors++; $display("FAIL wrap_base1: ready=%0b exp 0", b1.tx_req_ready); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alloc();
    test_window();
    test_nack_rt();
    test_round_robin();
    test_timeout();
    test_open();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
